param_sort_unit: RTL
====================

# param_sort_unit

Parametrised N-element sorter built on odd-even transposition, the next generation of the fixed 9-input bubble sort unit. It accepts a packed vector of N unsigned words on a start strobe and sorts it in place, one compare-exchange phase per clock. It then presents the sorted vector, the median element and a one-cycle valid pulse. It sits between the window buffer and the median-select stage of the median filter pipeline, and also serves as a general sorter for other window sizes.

## Interface
- BITWIDTH, default 8: element width in bits; comparisons are unsigned.
- NUM, default 9: element count, legal range 2..64.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start_i  in  1  request a sort; accepted only when busy_o = 0.
- desc_i  in  1  0 = ascending, 1 = descending; sampled with an accepted start.
- in_data_i  in  NUM*BITWIDTH  input vector; element k is at [k*BITWIDTH +: BITWIDTH]; sampled with an accepted start.
- out_data_o  out  NUM*BITWIDTH  sorted vector, same packing as in_data_i.
- median_o  out  BITWIDTH  sorted element NUM/2 (floor), taken from out_data_o.
- busy_o  out  1  high while in SORT.
- valid_o  out  1  one-cycle pulse; result complete.

## Operation
- State machine: IDLE, SORT, DONE.
  - IDLE → SORT on start_i.
  - SORT → DONE after the last phase.
  - DONE → SORT on start_i; otherwise DONE → IDLE.
- On an accepted start:
  - The element register array loads in_data_i and desc_i is latched.
  - The phase counter (width clog2(NUM+1)) clears to 0.
- Each SORT cycle executes phase p:
  - Even p compares the pairs (0,1),(2,3),…; odd p compares (1,2),(3,4),….
  - The unpaired last element holds its value.
  - A pair is swapped only if lower > upper (ascending) or lower < upper (descending). Equal elements are never swapped.
- Phase count: NUM phases (0..NUM-1), then DONE.
- out_data_o is driven directly from the element registers.
  - It is stable from valid_o until the next accepted start.
  - During SORT it shows intermediate contents and is not meaningful.
- start_i while busy_o = 1 is ignored, with no queueing.
- Reset values: state IDLE, element registers 0, out_data_o 0, median_o 0, busy_o 0, valid_o 0, phase counter 0.
- RST during SORT aborts the sort: the unit returns to IDLE with all-zero outputs and no valid_o pulse.

## Timing
- Edge E0 samples start_i = 1 (load). Edges E1..E_NUM execute phases 0..NUM-1.
- valid_o is high in the cycle after E_NUM, so start-to-valid latency is NUM+1 cycles (10 for NUM = 9).
- busy_o is high from the cycle after E0 through the cycle of E_NUM, for NUM cycles.
- valid_o = (state == DONE) and lasts exactly one cycle.
- start_i asserted in the DONE cycle is accepted, which gives back-to-back throughput of one sort per NUM+1 cycles.
- There is no combinational path from any input to any output.

## Configuration
- SORT_EARLY_EXIT_EN defined:
  - Each phase records whether any swap occurred.
  - After two consecutive phases with no swap, the FSM goes to DONE at the end of the second of them, even if phases remain.
  - Minimum latency is 3 cycles: an already-sorted input gives valid_o in the cycle after E2.
  - The NUM-phase limit still applies.
- SORT_EARLY_EXIT_EN undefined:
  - The swap-tracking logic is absent.
  - Latency is always NUM+1 cycles, independent of the data.

## Test plan
- NUM=9, BITWIDTH=8, ascending:
  - Stimulus: input 9 3 7 1 4 6 8 2 5, start.
  - Required: out 1 2 3 4 5 6 7 8 9, median_o = 5, valid_o exactly 10 cycles after the start edge, single cycle.
- Same input with desc_i = 1 → out 9 8 7 6 5 4 3 2 1, median_o = 5.
- Input already sorted 1..9, ascending → valid_o after 3 cycles with SORT_EARLY_EXIT_EN defined, after 10 cycles without it. The data are identical in both builds.
- Duplicates:
  - Input 4 4 2 2 9 9 0 0 4 → out 0 0 2 2 4 4 4 9 9, median_o = 4.
  - All-255 input → all 255.
- Busy and back-to-back:
  - start_i pulsed at cycle 3 of a running sort → ignored; the first result is unchanged.
  - start_i in the DONE cycle → a second valid_o exactly 10 cycles later with the new data.
- Reset and generic configuration:
  - RST asserted mid-SORT at phase 4 → next cycle busy_o = 0, out_data_o = 0, and no valid_o.
  - A re-run with NUM = 4, BITWIDTH = 16 and input 40000 5 65535 5 → out 5 5 40000 65535, median_o = 40000.

Source files
------------

// File: rtl/param_sort_unit_if.sv
// Handshake and data bundle for param_sort_unit.
// The master side issues sort requests; the slave side is the sorter.
// BITWIDTH and NUM must match the parameters of the attached sorter.
interface param_sort_unit_if #(
  parameter int BITWIDTH = 8,
  parameter int NUM      = 9
);
  logic                    start_i;
  logic                    desc_i;
  logic [NUM*BITWIDTH-1:0] in_data_i;
  logic [NUM*BITWIDTH-1:0] out_data_o;
  logic [BITWIDTH-1:0]     median_o;
  logic                    busy_o;
  logic                    valid_o;

  modport master (
    output start_i, desc_i, in_data_i,
    input  out_data_o, median_o, busy_o, valid_o
  );

  modport slave (
    input  start_i, desc_i, in_data_i,
    output out_data_o, median_o, busy_o, valid_o
  );
endinterface

// File: rtl/param_sort_unit.sv
// param_sort_unit: N-element odd-even transposition sorter.
// Loads a packed vector on an accepted start, runs one compare-exchange
// phase per clock for up to NUM phases, then pulses valid_o for one cycle.
// Optional feature macro: SORT_EARLY_EXIT_EN -- finish as soon as two
// consecutive phases perform no swap (minimum start-to-valid of 3 cycles).
module param_sort_unit #(
  parameter int BITWIDTH = 8,
  parameter int NUM      = 9
) (
  input  logic              CLK,
  input  logic              RST,
  param_sort_unit_if.slave  bus
);

  localparam int PW = $clog2(NUM + 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic                desc_q,  desc_d;
  logic [BITWIDTH-1:0] elem_q [NUM];
  logic [BITWIDTH-1:0] elem_d [NUM];

  // swap_w[i] is set when pair (i, i+1) belongs to the current phase and is out of order
  logic [NUM-2:0]      swap_w;

`ifdef SORT_EARLY_EXIT_EN
  // clean_q: the previous phase of this sort performed no swap
  logic                clean_q, clean_d;
  logic                any_swap;
  assign any_swap = |swap_w;
`endif

  genvar gi;

  // One comparator per adjacent pair; even pairs fire on even phases, odd on odd.
  // Equal elements never swap, so the sort is stable with respect to position.
  generate
    for (gi = 0; gi < NUM - 1; gi++) begin : g_pair
      localparam logic PAR = logic'(gi % 2);
      logic lo_gt_hi;
      logic lo_lt_hi;
      assign lo_gt_hi = elem_q[gi] > elem_q[gi+1];
      assign lo_lt_hi = elem_q[gi] < elem_q[gi+1];
      assign swap_w[gi] = (phase_q[0] == PAR) && (desc_q ? lo_lt_hi : lo_gt_hi);
    end
  endgenerate

  // Outputs come straight from registers, so no input reaches an output combinationally
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_out
      assign bus.out_data_o[gi*BITWIDTH +: BITWIDTH] = elem_q[gi];
    end
  endgenerate

  assign bus.median_o = elem_q[NUM/2];
  assign bus.busy_o   = (state_q == S_SORT);
  assign bus.valid_o  = (state_q == S_DONE);

  // Next-state logic: load on accepted start, apply one phase per SORT cycle
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    desc_d  = desc_q;
    for (int k = 0; k < NUM; k++) elem_d[k] = elem_q[k];
`ifdef SORT_EARLY_EXIT_EN
    clean_d = clean_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
          state_d = S_SORT;
          phase_d = '0;
          desc_d  = bus.desc_i;
          for (int k = 0; k < NUM; k++) elem_d[k] = bus.in_data_i[k*BITWIDTH +: BITWIDTH];
`ifdef SORT_EARLY_EXIT_EN
          clean_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SORT: begin
        // Active pairs never overlap within a phase, so at most one of the two
        // neighbouring swaps can move any given element.
        for (int k = 0; k < NUM; k++) begin
          if (k > 0 && swap_w[k-1]) elem_d[k] = elem_q[k-1];
          if (k < NUM - 1 && swap_w[k]) elem_d[k] = elem_q[k+1];
        end
        phase_d = phase_q + PW'(1);
`ifdef SORT_EARLY_EXIT_EN
        clean_d = ~any_swap;
        if (phase_q == LAST_PHASE || (clean_q && !any_swap)) state_d = S_DONE;
`else
        if (phase_q == LAST_PHASE) state_d = S_DONE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, phase counter, direction and element registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      desc_q  <= 1'b0;
      for (int k = 0; k < NUM; k++) elem_q[k] <= '0;
`ifdef SORT_EARLY_EXIT_EN
      clean_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      desc_q  <= desc_d;
      for (int k = 0; k < NUM; k++) elem_q[k] <= elem_d[k];
`ifdef SORT_EARLY_EXIT_EN
      clean_q <= clean_d;
`endif
    end
  end

endmodule
